// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register file write port, plus a zeroing sweep that clears every entry.
// A granted write reaches rf_* one cycle later. req_ready is held low during reset, while clearing, and when clr_start is high.
module regfile_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  rf_wr_en,
    output logic [AW-1:0]         rf_addr,
    output logic [WIDTH-1:0]      rf_wr_data,
    output logic [IDW-1:0]        grant_id,
    output logic                  err_oob
);

    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t           r_state;
    logic [IDW-1:0]   r_rr;

    logic             w_gnt_vld;
    logic [IDW-1:0]   w_gnt_idx;
    logic [AW-1:0]    w_gnt_addr;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_gnt_oob;
    logic [IDW-1:0]   w_rr_next;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // First valid requester at or after the round-robin pointer wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_vld && req_valid[wrap_add(r_rr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = wrap_add(r_rr, k);
            end
        end
        if (rst || r_state != ST_ARB || clr_start) begin
            w_gnt_vld = 1'b0;
        end
    end

    assign req_ready  = w_gnt_vld ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_gnt_addr = req_addr[w_gnt_idx*AW +: AW];
    assign w_gnt_data = req_data[w_gnt_idx*WIDTH +: WIDTH];
    assign w_gnt_oob  = {1'b0, w_gnt_addr} >= DEPTH_W;
    assign w_rr_next  = (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_rr       <= '0;
            clr_busy   <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            grant_id   <= '0;
            err_oob    <= 1'b0;
        end else begin
            err_oob <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (clr_start) begin
                        r_state    <= ST_CLEAR;
                        clr_busy   <= 1'b1;
                        rf_wr_en   <= 1'b1;
                        rf_addr    <= '0;
                        rf_wr_data <= '0;
                    end else if (w_gnt_vld) begin
                        r_rr <= w_rr_next;
                        if (w_gnt_oob) begin
                            rf_wr_en <= 1'b0;
                            err_oob  <= 1'b1;
                        end else begin
                            rf_wr_en   <= 1'b1;
                            rf_addr    <= w_gnt_addr;
                            rf_wr_data <= w_gnt_data;
                            grant_id   <= w_gnt_idx;
                        end
                    end else begin
                        rf_wr_en <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // rf_addr doubles as the sweep counter; data stays zero from entry.
                    if (rf_addr == LAST_ADR) begin
                        r_state  <= ST_ARB;
                        clr_busy <= 1'b0;
                        rf_wr_en <= 1'b0;
                    end else begin
                        rf_addr <= rf_addr + 1'b1;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

endmodule
